// File: rtl/l1_trace_gen_if.sv
// l1_trace_gen_if: spike/attention inputs and trace/attention outputs of the L1 trace generator
interface l1_trace_gen_if #(
   parameter int p_neurons = 2,
   parameter int p_width   = 9
);
   logic [p_neurons-1:0]         i_spike;
   logic                         i_gas;
   logic [p_neurons*p_width-1:0] o_tr;
   logic                         o_las;
   logic                         o_busy;
   logic                         o_drop;
   modport master (output i_spike, i_gas, input o_tr, o_las, o_busy, o_drop);
   modport slave  (input i_spike, i_gas, output o_tr, o_las, o_busy, o_drop);
endinterface

// File: rtl/l1_trace_gen.sv
// l1_trace_gen: picks one spiking L1 neuron, waits a fixed latency, pulses LAS, then emits a decaying trace
module l1_trace_gen #(
   parameter int p_neurons = 2,
   parameter int p_width   = 9,
   parameter int p_init    = 63,
   parameter int p_latency = 5
) (
   input logic            i_clk,
   input logic            i_rst,
   l1_trace_gen_if.slave  bus
);
   localparam int lw = $clog2(p_latency + 1);
   typedef enum logic [1:0] {idle, delay, las, trace} state_t;
   state_t               state, state_n;
   logic [p_neurons-1:0] spike_q, spike_prev, edges, win, win_n;
   logic [lw-1:0]        dcnt, dcnt_n;
   logic [p_width-1:0]   tcnt, tcnt_n;
   logic                 drop_n;
   assign edges = spike_q & ~spike_prev;
   // state, counters, spike history and the registered status outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= idle;
         spike_q    <= '0;
         spike_prev <= '0;
         win        <= '0;
         dcnt       <= '0;
         tcnt       <= '0;
         bus.o_las  <= 1'b0;
         bus.o_busy <= 1'b0;
         bus.o_drop <= 1'b0;
      end else begin
         state      <= state_n;
         spike_q    <= bus.i_spike;
         spike_prev <= spike_q;
         win        <= win_n;
         dcnt       <= dcnt_n;
         tcnt       <= tcnt_n;
         bus.o_las  <= state_n == las;
         bus.o_busy <= state_n != idle;
         bus.o_drop <= drop_n;
      end
   end
   // sequencing: latch the lowest-index edge as a one-hot winner, count the delay, then the trace
   always_comb begin
      state_n = state;
      win_n   = win;
      dcnt_n  = dcnt;
      tcnt_n  = tcnt;
      case (state)
         idle:
            if (bus.i_gas && |edges) begin
               state_n = delay;
               win_n   = edges & (~edges + p_neurons'(1));
               dcnt_n  = lw'(p_latency);
            end
         delay: begin
            dcnt_n  = dcnt - lw'(1);
            state_n = dcnt == lw'(1) ? las : delay;
         end
         las: begin
            state_n = trace;
            tcnt_n  = p_width'(p_init);
         end
         trace: begin
            state_n = tcnt == p_width'(1) ? idle : trace;
            tcnt_n  = tcnt == p_width'(1) ? '0 : tcnt - p_width'(1);
         end
      endcase
   end
   // drop losers of a simultaneous edge or any gated edge while busy; show the winner's trace only
   always_comb begin
      drop_n   = bus.i_gas && (state == idle ? |(edges & (edges - p_neurons'(1))) : |edges);
      bus.o_tr = '0;
      for (int n = 0; n < p_neurons; n++)
         if (state == trace && win[n]) bus.o_tr[n*p_width +: p_width] = tcnt;
   end
endmodule
